// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, types and helpers for the register-file writeback arbiter.
// Optional conflict statistics are enabled by defining WB_STATS_EN.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } hold_entry_t;

    localparam hold_entry_t HOLD_EMPTY = '{valid: 1'b0, addr: 5'd0, data: 32'd0};

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        reg_onehot = 32'd1 << addr;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two requester handshakes plus the register-file write port and BUSY.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                  A_VLD;
    logic [REG_ADDR_W-1:0] A_RW;
    logic [REG_DATA_W-1:0] A_PW;
    logic                  A_RDY;
    logic                  B_VLD;
    logic [REG_ADDR_W-1:0] B_RW;
    logic [REG_DATA_W-1:0] B_PW;
    logic                  B_RDY;
    logic                  EN;
    logic [REG_ADDR_W-1:0] RW;
    logic [REG_DATA_W-1:0] PW;
    logic [NUM_REGS-1:0]   BUSY;

    modport slave (
        input  A_VLD, A_RW, A_PW, B_VLD, B_RW, B_PW,
        output A_RDY, B_RDY, EN, RW, PW, BUSY
    );

    modport master (
        output A_VLD, A_RW, A_PW, B_VLD, B_RW, B_PW,
        input  A_RDY, B_RDY, EN, RW, PW, BUSY
    );

endinterface

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a writeback requester; frees itself when granted.
module wb_hold_slot
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_vld,
    input  logic [REG_ADDR_W-1:0] i_addr,
    input  logic [REG_DATA_W-1:0] i_data,
    input  logic                  i_grant,
    output logic                  o_rdy,
    output hold_entry_t           o_entry
);

    hold_entry_t r_entry;
    logic        w_load;

    // Ready while empty or while the entry drains this cycle, never during reset.
    assign o_rdy   = !i_rst && (!r_entry.valid || i_grant);
    assign w_load  = i_vld && o_rdy;
    assign o_entry = r_entry;

    // Entry register: a same-edge reload takes priority over the grant clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_entry <= HOLD_EMPTY;
        end else if (w_load) begin
            r_entry <= '{valid: 1'b1, addr: i_addr, data: i_data};
        end else if (i_grant) begin
            r_entry.valid <= 1'b0;
        end else begin
            r_entry <= r_entry;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with round-robin on contention.
// Define WB_STATS_EN to add the saturating CONFLICT_CNT output.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    regfile_wb_arbiter_if.slave  wb
`ifdef WB_STATS_EN
    ,
    output logic [15:0]          CONFLICT_CNT
`endif
);

    hold_entry_t           w_entry_a;
    hold_entry_t           w_entry_b;
    logic                  w_rdy_a;
    logic                  w_rdy_b;
    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_win;
    logic [REG_ADDR_W-1:0] w_win_addr;
    logic [REG_DATA_W-1:0] w_win_data;
    logic [NUM_REGS-1:0]   w_busy;

    req_e                  r_last;
    logic                  r_en;
    logic [REG_ADDR_W-1:0] r_rw;
    logic [REG_DATA_W-1:0] r_pw;

    wb_hold_slot u_hold_a (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_vld   (wb.A_VLD),
        .i_addr  (wb.A_RW),
        .i_data  (wb.A_PW),
        .i_grant (w_grant_a),
        .o_rdy   (w_rdy_a),
        .o_entry (w_entry_a)
    );

    wb_hold_slot u_hold_b (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_vld   (wb.B_VLD),
        .i_addr  (wb.B_RW),
        .i_data  (wb.B_PW),
        .i_grant (w_grant_b),
        .o_rdy   (w_rdy_b),
        .o_entry (w_entry_b)
    );

    assign wb.A_RDY = w_rdy_a;
    assign wb.B_RDY = w_rdy_b;

    // Grant selection: a lone valid entry wins; on contention the side not served last wins.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (RST) begin
            w_grant_a = 1'b0;
            w_grant_b = 1'b0;
        end else begin
            case ({w_entry_a.valid, w_entry_b.valid})
                2'b10:   w_grant_a = 1'b1;
                2'b01:   w_grant_b = 1'b1;
                2'b11: begin
                    w_grant_a = (r_last == REQ_B);
                    w_grant_b = (r_last == REQ_A);
                end
                default: begin
                    w_grant_a = 1'b0;
                    w_grant_b = 1'b0;
                end
            endcase
        end
    end

    // Winner mux feeding the output registers.
    always_comb begin
        w_win      = 1'b0;
        w_win_addr = w_entry_a.addr;
        w_win_data = w_entry_a.data;
        if (w_grant_a) begin
            w_win      = 1'b1;
        end else if (w_grant_b) begin
            w_win      = 1'b1;
            w_win_addr = w_entry_b.addr;
            w_win_data = w_entry_b.data;
        end else begin
            w_win      = 1'b0;
        end
    end

    // Output write port and round-robin pointer; GR0 writes are consumed silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_en   <= 1'b0;
            r_rw   <= 5'd0;
            r_pw   <= 32'd0;
            r_last <= REQ_B;
        end else if (w_win) begin
            r_last <= w_grant_a ? REQ_A : REQ_B;
            if (w_win_addr != 5'd0) begin
                r_en <= 1'b1;
                r_rw <= w_win_addr;
                r_pw <= w_win_data;
            end else begin
                r_en <= 1'b0;
            end
        end else begin
            r_en <= 1'b0;
        end
    end

    assign wb.EN = r_en;
    assign wb.RW = r_rw;
    assign wb.PW = r_pw;

    // Pending-write scoreboard over both holds and the write port.
    always_comb begin
        w_busy = 32'd0;
        if (RST) begin
            w_busy = 32'd0;
        end else begin
            if (w_entry_a.valid) begin
                w_busy = w_busy | reg_onehot(w_entry_a.addr);
            end else begin
                w_busy = w_busy;
            end
            if (w_entry_b.valid) begin
                w_busy = w_busy | reg_onehot(w_entry_b.addr);
            end else begin
                w_busy = w_busy;
            end
            if (r_en) begin
                w_busy = w_busy | reg_onehot(r_rw);
            end else begin
                w_busy = w_busy;
            end
            w_busy[0] = 1'b0;
        end
    end

    assign wb.BUSY = w_busy;

`ifdef WB_STATS_EN
    logic [15:0] r_conflict_cnt;

    // Saturating count of cycles with both holds occupied.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_conflict_cnt <= 16'd0;
        end else if (w_entry_a.valid && w_entry_b.valid && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end else begin
            r_conflict_cnt <= r_conflict_cnt;
        end
    end

    assign CONFLICT_CNT = r_conflict_cnt;
`endif

endmodule
